// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: op codes, FSM states,
// pipeline constants and small op-decoding helpers.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  localparam logic [4:0]  NOPRegAddr   = 5'd0;
  localparam logic [31:0] ZeroWord     = 32'd0;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [1:0]  HaltBubble   = 2'b11;

  function automatic logic is_load(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: is_load = 1'b1;
      default:                                  is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    case (op)
      MEM_SB, MEM_SH, MEM_SW: is_store = 1'b1;
      default:                is_store = 1'b0;
    endcase
  endfunction

  // Undefined op codes decode as neither load nor store, i.e. as NONE.
  function automatic logic is_mem_op(input logic [3:0] op);
    is_mem_op = is_load(op) | is_store(op);
  endfunction

  function automatic logic [2:0] op_bytes(input logic [3:0] op);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: op_bytes = 3'd2;
      MEM_LW, MEM_SW:          op_bytes = 3'd4;
      default:                 op_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide request/acknowledge memory port between the memory stage
// (master) and the data memory (slave).
interface mem_stage_if #(
  parameter int ADDR_W = 32
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wbyte;
  logic              ack;
  logic [7:0]        rbyte;

  modport master (output req, we, addr, wbyte, input ack, rbyte);
  modport slave  (input req, we, addr, wbyte, output ack, rbyte);

endinterface

// File: rtl/mem_stage_ld_ext.sv
// Load extension: widens the assembled load buffer to 32 bits according
// to the load op (sign- or zero-extension).
module mem_stage_ld_ext
  import mem_stage_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] buf_i,
  output logic [31:0] data_o
);

  // Select extension by op; LW and anything else pass the buffer unchanged.
  always_comb begin
    data_o = buf_i;
    case (op_i)
      MEM_LB:  data_o = {{24{buf_i[7]}}, buf_i[7:0]};
      MEM_LH:  data_o = {{16{buf_i[15]}}, buf_i[15:0]};
      MEM_LBU: data_o = {24'd0, buf_i[7:0]};
      MEM_LHU: data_o = {16'd0, buf_i[15:0]};
      default: data_o = buf_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: ALU results pass through, loads/stores run
// as little-endian byte-serial transactions while stalling the pipeline.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic [31:0]       ex_wdata_i,
  input  logic [3:0]        ex_mem_op_i,
  input  logic [ADDR_W-1:0] ex_mem_addr_i,
  input  logic [31:0]       ex_store_data_i,
  mem_stage_if.master       mem_bus,
  output logic [4:0]        mem_wd_o,
  output logic              mem_wreg_o,
  output logic [31:0]       mem_wdata_o,
  output logic              stall_req_o
);

  mem_state_e        state_q, state_d;
  logic [1:0]        k_q;
  logic [2:0]        n_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sdata_q;
  logic [31:0]       buf_q;
  logic [4:0]        wd_q;
  logic              wreg_q;

  logic              last_s;
  logic [31:0]       ext_s;
  logic              req_s, we_s, stall_s, wreg_s;
  logic [ADDR_W-1:0] addr_s;
  logic [7:0]        wbyte_s;
  logic [4:0]        wd_s;
  logic [31:0]       wdata_s;

  assign last_s = ({1'b0, k_q} == (n_q - 3'd1));

  mem_stage_ld_ext u_ld_ext (
    .op_i   (op_q),
    .buf_i  (buf_q),
    .data_o (ext_s)
  );

  // Next-state and output decode for the IDLE/ACCESS/DONE sequencer.
  always_comb begin
    state_d = state_q;
    req_s   = 1'b0;
    we_s    = 1'b0;
    addr_s  = '0;
    wbyte_s = 8'h00;
    stall_s = 1'b0;
    wd_s    = NOPRegAddr;
    wreg_s  = WriteDisable;
    wdata_s = ZeroWord;
    case (state_q)
      ST_IDLE: begin
        if (is_mem_op(ex_mem_op_i)) begin
          stall_s = 1'b1;
          state_d = ST_ACCESS;
        end else begin
          wd_s    = ex_wd_i;
          wreg_s  = ex_wreg_i;
          wdata_s = ex_wdata_i;
        end
      end
      ST_ACCESS: begin
        req_s   = 1'b1;
        stall_s = 1'b1;
        addr_s  = addr_q + ADDR_W'(k_q);
        we_s    = is_store(op_q);
        if (is_store(op_q)) begin
          wbyte_s = sdata_q[{k_q, 3'b000} +: 8];
        end else begin
          wbyte_s = 8'h00;
        end
        if (mem_bus.ack && last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (is_load(op_q)) begin
          wd_s    = wd_q;
          wreg_s  = wreg_q;
          wdata_s = ext_s;
        end else begin
          wd_s    = NOPRegAddr;
          wreg_s  = WriteDisable;
          wdata_s = ZeroWord;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset forces every control output quiet, including the pass-through path.
  assign mem_bus.req   = rst ? 1'b0 : req_s;
  assign mem_bus.we    = rst ? 1'b0 : we_s;
  assign mem_bus.addr  = addr_s;
  assign mem_bus.wbyte = wbyte_s;
  assign stall_req_o   = rst ? 1'b0 : stall_s;
  assign mem_wd_o      = rst ? NOPRegAddr : wd_s;
  assign mem_wreg_o    = rst ? WriteDisable : wreg_s;
  assign mem_wdata_o   = rst ? ZeroWord : wdata_s;

  // State, operand latches, byte index and load assembly buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= 2'd0;
      n_q     <= 3'd1;
      op_q    <= MEM_NONE;
      addr_q  <= '0;
      sdata_q <= 32'd0;
      buf_q   <= 32'd0;
      wd_q    <= 5'd0;
      wreg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (is_mem_op(ex_mem_op_i)) begin
            op_q    <= ex_mem_op_i;
            addr_q  <= ex_mem_addr_i;
            sdata_q <= ex_store_data_i;
            wd_q    <= ex_wd_i;
            wreg_q  <= ex_wreg_i;
            k_q     <= 2'd0;
            n_q     <= op_bytes(ex_mem_op_i);
            buf_q   <= 32'd0;
          end
        end
        ST_ACCESS: begin
          if (mem_bus.ack) begin
            if (is_load(op_q)) begin
              buf_q[{k_q, 3'b000} +: 8] <= mem_bus.rbyte;
            end
            if (!last_s) begin
              k_q <= k_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and `mem_wb`. ALU results pass straight through. Loads and stores are carried out as a sequence of byte transactions on an 8-bit request/acknowledge memory port. While an access is in progress the block holds `stall_req`, so the stall controller freezes the upstream stages and bubbles `mem_wb` (halt code 2'b11).

## Interface
Parameters:
- `ADDR_W`, 32: memory address width.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset rst, synchronous, active-high; clock clk
- `ex_wd`  in  5  destination register
- `ex_wreg`  in  1  register write enable
- `ex_wdata`  in  32  ALU result (non-memory ops)
- `ex_mem_op`  in  4  memory op code: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW
- `ex_mem_addr`  in  ADDR_W  effective address
- `ex_store_data`  in  32  rs2 value for stores
- `mem_req`  out  1  byte transaction request, level
- `mem_we`  out  1  1 = write byte, 0 = read byte
- `mem_addr`  out  ADDR_W  byte address
- `mem_wbyte`  out  8  write byte
- `mem_ack`  in  1  one-cycle pulse; transaction complete
- `mem_rbyte`  in  8  read byte, valid with `mem_ack`
- `mem_wd`  out  5  to `mem_wb`
- `mem_wreg`  out  1  to `mem_wb`
- `mem_wdata`  out  32  to `mem_wb`
- `stall_req`  out  1  to the stall controller

## Operation
States are IDLE, ACCESS and DONE. Internal registers:
- byte index `k` (2 bits)
- byte count `n`
- latched op, address, store data, `wd` and `wreg`
- 32-bit assembly buffer `buf`

IDLE:
- If `ex_mem_op`=NONE, pass through combinationally: `mem_wd`=`ex_wd`, `mem_wreg`=`ex_wreg`, `mem_wdata`=`ex_wdata`. `stall_req`=0.
- If `ex_mem_op` is a load or store:
  - Outputs `stall_req`=1 and `mem_wreg`=0 combinationally.
  - At the clock edge: latch the operands, set `k`=0, set `n`=1/2/4 for byte/half/word ops, clear `buf`, go to ACCESS.

ACCESS:
- `mem_req`=1, `mem_addr`=latched address + `k` (mod 2^ADDR_W, wraps past all-ones).
- `mem_we`=1 for stores, with `mem_wbyte`=store_data[8k+7:8k].
- `stall_req`=1, `mem_wreg`=0.
- On `mem_ack`:
  - Loads: `buf[8k+7:8k]`←`mem_rbyte`.
  - If `k`=`n`−1, go to DONE; otherwise `k`++.
- No timeout.

DONE (exactly one cycle):
- `mem_req`=0, `stall_req`=0.
- Loads: `mem_wd`/`mem_wreg` come from the latched values. `mem_wdata` is `buf` extended to 32 bits:
  - LB/LH: sign-extended from bit 7 or bit 15.
  - LBU/LHU: zero-extended.
  - LW: unchanged.
- Stores: `mem_wreg`=0, `mem_wd`=NOP register (0), `mem_wdata`=0.
- Next state is IDLE unconditionally. The op still visible on `ex_*` during DONE is the one just completed; it is not restarted, because the pipeline advances at this edge.

Boundary rules:
- Little-endian byte order. Byte-serial access, so misaligned addresses are legal and need no special handling.
- `mem_ack` while `mem_req`=0 is ignored.
- Op codes outside the defined set are treated as NONE.
- `rst` mid-access: state→IDLE and `k`→0 at that edge, so `mem_req` is 0 from the next cycle. A partial store is not rolled back.

Reset values, while `rst` is held:
- Registered state: IDLE, `k`=0, `buf`=0, latched wd/wreg=0.
- `mem_req`=0, `mem_we`=0, `stall_req`=0, `mem_wreg`=0, `mem_wd`=0, `mem_wdata`=0. All outputs are forced to these values while `rst`=1.

## Timing
- Non-memory op: zero added latency, combinational pass-through.
- Memory op arriving in cycle 0 (IDLE): `stall_req` high in cycle 0.
- First `mem_req` in cycle 1. Each byte completes on its `mem_ack`; the next byte is presented in the following cycle.
- With `mem_ack` in the same cycle as every request:
  - byte ops reach DONE in cycle 2;
  - half ops in cycle 3;
  - word ops in cycle 5.
- `stall_req` stays high from cycle 0 up to, but not including, DONE. `mem_wb` captures the result on the edge ending DONE.
- `mem_addr`, `mem_we` and `mem_wbyte` are stable for as long as `mem_req` is high for a given byte.

## Structure
- Shared defines:
  - memory op codes (4-bit);
  - state encodings;
  - `NOPRegAddr`, `ZeroWord`, `WriteDisable`;
  - the halt code 2'b11 (bubble) used by the stall controller.
- One sub-module, `ld_ext`: combinational; takes op + 32-bit `buf` and returns the extended load value.

## Test plan
- ADD result passes through: `ex_wdata`=0x1234, `ex_wd`=5 → same cycle `mem_wdata`=0x1234, `mem_wd`=5, `mem_wreg`=1, `stall_req`=0.
- LW at 0x100, memory bytes 0x78,0x56,0x34,0x12, ack every cycle → requests to addresses 0x100–0x103 in cycles 1–4, `stall_req` high in cycles 0–4, cycle 5 `mem_wdata`=0x12345678.
- LB and LBU from a byte 0x80 → 0xFFFFFF80 and 0x00000080. LH of 0x80,0xFF → 0xFFFFFF80.
- SH of 0xAABBCCDD at 0xFFFFFFFF, ack delayed 3 cycles per byte → writes 0xDD to 0xFFFFFFFF and 0xCC to 0x00000000; `mem_wreg`=0 in DONE; address and data held stable while waiting.
- `rst` asserted in the middle of a word store, after byte 1 → `mem_req`=0 the next cycle, state IDLE, `stall_req`=0; a following LB completes normally.
- Spurious `mem_ack` in IDLE, then back-to-back LW, LW → the spurious ack has no effect; the second load starts in the cycle after DONE and is not merged with the first.
